// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST conv1 input path.
// Image geometry plus the pixel-stream transmitter state encoding.
package mnist_pkg;

    localparam int IMG_WIDTH  = 28;
    localparam int IMG_HEIGHT = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/frame_store.sv
// HEIGHT x WIDTH 1-bit image store: one synchronous row-write port and one
// combinational row-read port. Cleared to zeros by reset.
module frame_store #(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [$clog2(HEIGHT)-1:0] waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [$clog2(HEIGHT)-1:0] raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [HEIGHT];

    // The caller guarantees waddr_i < HEIGHT whenever we_i is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < HEIGHT; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_stream_tx.sv
// Streams a stored binary image in raster order as a valid/pixel stream.
// Define PIXEL_STREAM_ROW_GAP_EN to insert one idle GAP cycle between rows.
module pixel_stream_tx
    import mnist_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      row_we,
    input  logic [$clog2(HEIGHT)-1:0] row_addr,
    input  logic [WIDTH-1:0]          row_data,
    input  logic                      start,
    input  logic                      pause,
    output logic                      valid_out,
    output logic                      pixel_out,
    output logic                      busy,
    output logic                      done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    tx_state_t        state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             valid_q, valid_d;
    logic             pixel_q, pixel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] row_rd;
    logic             store_we;
    logic             last_col;
    logic             last_row;

    // Frame is only writable while idle so a transmit always sees one image.
    assign store_we = row_we && (state_q == IDLE) && (int'(row_addr) < HEIGHT);
    assign last_col = (x_q == XW'(WIDTH - 1));
    assign last_row = (y_q == YW'(HEIGHT - 1));

    frame_store #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_frame_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (store_we),
        .waddr_i (row_addr),
        .wdata_i (row_data),
        .raddr_i (y_q),
        .rdata_o (row_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            pixel_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            pixel_q <= pixel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            STREAM: begin
                if (!pause) begin
                    if (!last_col) begin
                        x_d = x_q + XW'(1);
                    end else if (last_row) begin
                        // Counters hold at the last pixel; start reloads them.
                        state_d = DONE;
                    end else begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
`ifdef PIXEL_STREAM_ROW_GAP_EN
                        state_d = GAP;
`endif
                    end
                end
            end
`ifdef PIXEL_STREAM_ROW_GAP_EN
            GAP:     state_d = STREAM;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        pixel_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE:   busy_d = start;
            STREAM: begin
                busy_d = 1'b1;
                if (!pause) begin
                    valid_d = 1'b1;
                    pixel_d = row_rd[x_q];
                end
            end
`ifdef PIXEL_STREAM_ROW_GAP_EN
            GAP:    busy_d = 1'b1;
`endif
            DONE:   done_d = 1'b1;
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign valid_out = valid_q;
    assign pixel_out = pixel_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: checkerboard, single-pixel, pause,
// ignored writes/starts, retransmit and mid-frame reset scenarios.
module tb_pixel_stream_tx;
    import mnist_pkg::*;

    localparam int W    = IMG_WIDTH;
    localparam int H    = IMG_HEIGHT;
    localparam int NPIX = W * H;
`ifdef PIXEL_STREAM_ROW_GAP_EN
    localparam int GAPS = H - 1;
`else
    localparam int GAPS = 0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 row_we;
    logic [$clog2(H)-1:0] row_addr;
    logic [W-1:0]         row_data;
    logic                 start;
    logic                 pause;
    logic                 valid_out;
    logic                 pixel_out;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model [H];
    logic [0:0]   exp_q [$];

    pixel_stream_tx #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_we    (row_we),
        .row_addr  (row_addr),
        .row_data  (row_data),
        .start     (start),
        .pause     (pause),
        .valid_out (valid_out),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_row(input int addr, input logic [W-1:0] data);
        @(negedge clk);
        row_we   = 1'b1;
        row_addr = addr[$clog2(H)-1:0];
        row_data = data;
        if (addr < H) model[addr] = data;
        @(negedge clk);
        row_we = 1'b0;
    endtask

    // Starts a frame at the current negedge and scores every output cycle.
    task automatic stream_frame(input string tag, input int pause_idx, input int pause_len,
                                input int abort_at, input bit disturb,
                                output int ones, output int first_one);
        int k;
        int bubbles;
        int cyc;
        int done_cyc;
        int pause_left;
        logic [0:0] e;
        k = 0; bubbles = 0; cyc = 0; done_cyc = -1; pause_left = pause_len;
        ones = 0; first_one = -1;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(model[i / W][i % W]);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        row_we = 1'b0;
        check({tag, "_lat_valid"}, valid_out, 0);
        check({tag, "_lat_busy"}, busy, 1);
        while (cyc < 3000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_valid"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_pix"}, pixel_out, e);
                end
                if (pixel_out) begin
                    if (first_one < 0) first_one = k;
                    ones++;
                end
                k++;
            end else begin
                check({tag, "_bubble_pix"}, pixel_out, 0);
                if (!done) begin
                    bubbles++;
                    if (pause_len == 0) check({tag, "_gap_pos"}, k % W, 0);
                end
            end
            if (done) done_cyc = cyc;
            if (abort_at >= 0 && k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check({tag, "_rst_valid"}, valid_out, 0);
                check({tag, "_rst_pix"}, pixel_out, 0);
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                exp_q.delete();
                for (int r = 0; r < H; r++) model[r] = '0;
                pause = 1'b0;
                return;
            end
            if (pause_idx >= 0 && k == pause_idx && pause_left > 0) begin
                pause = 1'b1;
                pause_left--;
            end else begin
                pause = 1'b0;
            end
            if (disturb && k == 50 && valid_out) begin
                row_we   = 1'b1;
                row_addr = 3;
                row_data = '1;
                start    = 1'b1;
            end else begin
                row_we = 1'b0;
                start  = 1'b0;
            end
        end
        pause = 1'b0;
        if (done_cyc < 0) check({tag, "_timeout"}, 1, 0);
        check({tag, "_nvalid"}, k, NPIX);
        check({tag, "_bubbles"}, bubbles, pause_len + GAPS);
        check({tag, "_done_cyc"}, done_cyc, NPIX + pause_len + GAPS + 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int ones;
        int first_one;
        rst_n    = 1'b0;
        row_we   = 1'b0;
        row_addr = '0;
        row_data = '0;
        start    = 1'b0;
        pause    = 1'b0;
        for (int r = 0; r < H; r++) model[r] = '0;
        #22;
        check("rst_valid", valid_out, 0);
        check("rst_pix", pixel_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Checkerboard; row 0 is written in the same cycle as start.
        for (int r = 1; r < H; r++) write_row(r, (r % 2 == 0) ? 28'h5555555 : 28'hAAAAAAA);
        row_we   = 1'b1;
        row_addr = 0;
        row_data = 28'h5555555;
        model[0] = 28'h5555555;
        stream_frame("checker", -1, 0, -1, 1'b0, ones, first_one);
        check("checker_ones", ones, NPIX / 2);
        check("checker_first", first_one, 0);

        // Retransmit with a 3-cycle pause at pixel 100 and ignored write/start.
        stream_frame("pause", 100, 3, -1, 1'b1, ones, first_one);
        check("pause_ones", ones, NPIX / 2);

        // Single pixel at row 5, column 27; out-of-range write ignored.
        for (int r = 0; r < H; r++) write_row(r, (r == 5) ? 28'h8000000 : 28'h0);
        write_row(30, '1);
        stream_frame("single", -1, 0, -1, 1'b0, ones, first_one);
        check("single_ones", ones, 1);
        check("single_idx", first_one, 5 * W + 27);

        // Reset mid-frame, then an all-zero frame proves the store was cleared.
        for (int r = 0; r < H; r++) write_row(r, '1);
        stream_frame("abort", -1, 0, 400, 1'b0, ones, first_one);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_busy", busy, 0);
        stream_frame("cleared", -1, 0, -1, 1'b0, ones, first_one);
        check("cleared_ones", ones, 0);
        for (int r = 0; r < H; r++) write_row(r, '1);
        stream_frame("ones", -1, 0, -1, 1'b0, ones, first_one);
        check("ones_count", ones, NPIX);
        check("ones_first", first_one, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
